array_allocator: RTL and testbench

- Clocked allocator for the array-handle space used by the VM heap. Hands out array ids, recycles freed ids through a LIFO free stack, and shares that service between NReq requesters (execution units, I/O loader) using round-robin arbitration.
- Drives the clear port of the arraySizes table: zeroes the whole table after reset, then zeroes an array's size entry whenever that array is allocated.
- Tracks live and high-water allocation counts for the finish/success checker.

---
 rtl/array_alloc_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/array_allocator.sv | 201 ++++++++++++++++++++
 tb/tb_array_allocator.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_alloc_pkg.sv
// Shared types and default sizing for the array-handle allocator.
//   array_id_t    : one array id (also the width of the allocation counts)
//   alloc_state_e : allocator FSM states (INIT sweep, RUN service)
//   Default*      : default id width, number of array ids, number of requesters
package array_alloc_pkg;

  localparam int DefaultIdWidth = 12;
  localparam int DefaultNArrays = 16;
  localparam int DefaultNReq    = 2;

  typedef logic [DefaultIdWidth-1:0] array_id_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping around.
//   req   : request vector
//   ptr   : requester index with highest priority this cycle
//   gnt   : one-hot pick (all zero when nothing requests)
//   found : high when gnt has a bit set
module rr_arbiter #(
  parameter int N    = 2,
  parameter int PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic            found
);

  logic [PtrW-1:0] idx_s;

  // Scan from ptr upward; the first request seen wins and masks the rest.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx_s = '0;
    for (int off = 0; off < N; off++) begin
      idx_s      = PtrW'((int'(ptr) + off) % N);
      gnt[idx_s] = req[idx_s] & ~found;
      found      = found | req[idx_s];
    end
  end

endmodule

// File: rtl/array_allocator.sv
// Array-id allocator for the VM heap: hands out ids (recycled ids from a LIFO
// free stack first, then fresh ones), accepts frees, and round-robins both
// services between NReq requesters. After reset it sweeps the arraySizes
// table clear, then clears an entry each time its id is granted.
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   ready                : high once the clear sweep is finished
//   alloc_req/gnt/id     : allocate handshake, grant is a one-cycle one-hot pulse
//   alloc_full           : chosen requester could not be served (no id left)
//   free_req/id/ack      : free handshake, free_id packs one id per requester
//   err_bad_free         : the acknowledged free was rejected
//   size_clr/size_clr_id : clear strobe and entry for the arraySizes table
//   in_use, high_water   : live ids and ids ever issued from the fresh counter
module array_allocator
  import array_alloc_pkg::*;
#(
  parameter int MemoryElementWidth = DefaultIdWidth,
  parameter int NArrays            = DefaultNArrays,
  parameter int NReq               = DefaultNReq
) (
  input  logic                            clock,
  input  logic                            reset,
  output logic                            ready,
  input  logic [NReq-1:0]                 alloc_req,
  output logic [NReq-1:0]                 alloc_gnt,
  output logic [MemoryElementWidth-1:0]   alloc_id,
  output logic                            alloc_full,
  input  logic [NReq-1:0]                 free_req,
  input  logic [NReq*MemoryElementWidth-1:0] free_id,
  output logic [NReq-1:0]                 free_ack,
  output logic                            err_bad_free,
  output logic                            size_clr,
  output logic [MemoryElementWidth-1:0]   size_clr_id,
  output logic [MemoryElementWidth-1:0]   in_use,
  output logic [MemoryElementWidth-1:0]   high_water
);

  localparam int W    = MemoryElementWidth;
  localparam int PtrW = (NReq > 1) ? $clog2(NReq) : 1;
  localparam int IdxW = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam logic [W-1:0] LastId  = W'(NArrays - 1);
  localparam logic [W-1:0] IdCount = W'(NArrays);

  alloc_state_e    state_r;
  logic [W-1:0]    sweep_r;
  logic [W-1:0]    fresh_r;
  logic [W-1:0]    stackTop_r;
  logic [W-1:0]    stack_r [NArrays];
  logic [NArrays-1:0] inUseMap_r;
  logic [PtrW-1:0] allocPtr_r;
  logic [PtrW-1:0] freePtr_r;

  logic [NReq-1:0] allocElig_s, freeElig_s;
  logic [NReq-1:0] allocPick_s, freePick_s;
  logic            allocFound_s, freeFound_s;
  logic [PtrW-1:0] allocIdx_s, freeIdx_s;
  logic [PtrW-1:0] allocPtrNext_s, freePtrNext_s;
  logic [W-1:0]    freeSel_s;
  logic [W-1:0]    grantId_s;
  logic [IdxW-1:0] popIdx_s, pushIdx_s;
  logic            running_s, stackEmpty_s, freshLeft_s;
  logic            doPop_s, doFresh_s, doFull_s, doGrant_s;
  logic            freeKnown_s, freeValid_s, freeBad_s;

  assign high_water = fresh_r;

  // A requester being acknowledged this cycle is not eligible again until
  // its pulse has gone, so a still-held request is never served twice.
  assign allocElig_s = alloc_req & ~alloc_gnt;
  assign freeElig_s  = free_req & ~free_ack;

  rr_arbiter #(.N(NReq), .PtrW(PtrW)) u_allocArb (
    .req   (allocElig_s),
    .ptr   (allocPtr_r),
    .gnt   (allocPick_s),
    .found (allocFound_s)
  );

  rr_arbiter #(.N(NReq), .PtrW(PtrW)) u_freeArb (
    .req   (freeElig_s),
    .ptr   (freePtr_r),
    .gnt   (freePick_s),
    .found (freeFound_s)
  );

  // Decode the picks and decide this cycle's alloc and free outcomes.
  always_comb begin
    allocIdx_s = '0;
    freeIdx_s  = '0;
    freeSel_s  = '0;
    for (int i = 0; i < NReq; i++) begin
      allocIdx_s = allocIdx_s | (allocPick_s[i] ? PtrW'(i) : '0);
      freeIdx_s  = freeIdx_s  | (freePick_s[i]  ? PtrW'(i) : '0);
      freeSel_s  = freeSel_s  | (free_id[i*W +: W] & {W{freePick_s[i]}});
    end
    allocPtrNext_s = (allocIdx_s == PtrW'(NReq - 1)) ? '0 : allocIdx_s + PtrW'(1);
    freePtrNext_s  = (freeIdx_s  == PtrW'(NReq - 1)) ? '0 : freeIdx_s  + PtrW'(1);

    running_s    = (state_r == RUN);
    stackEmpty_s = (stackTop_r == '0);
    popIdx_s     = IdxW'(stackTop_r - W'(1));
    pushIdx_s    = IdxW'(stackTop_r);
    freshLeft_s  = (fresh_r < IdCount);

    // The pop looks at the stack as it stood before this cycle's push.
    doPop_s   = running_s & allocFound_s & ~stackEmpty_s;
    doFresh_s = running_s & allocFound_s & stackEmpty_s & freshLeft_s;
    doFull_s  = running_s & allocFound_s & stackEmpty_s & ~freshLeft_s;
    doGrant_s = doPop_s | doFresh_s;
    grantId_s = doPop_s ? stack_r[popIdx_s] : fresh_r;

    // id < fresh keeps the bitmap index in range before it is used.
    freeKnown_s = (freeSel_s < fresh_r) && inUseMap_r[freeSel_s[IdxW-1:0]];
    freeValid_s = running_s & freeFound_s & freeKnown_s;
    freeBad_s   = running_s & freeFound_s & ~freeKnown_s;
  end

  // FSM, free stack, bitmap, counters and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= INIT;
      sweep_r      <= '0;
      fresh_r      <= '0;
      stackTop_r   <= '0;
      inUseMap_r   <= '0;
      allocPtr_r   <= '0;
      freePtr_r    <= '0;
      for (int i = 0; i < NArrays; i++) begin
        stack_r[i] <= '0;
      end
      ready        <= 1'b0;
      alloc_gnt    <= '0;
      alloc_id     <= '0;
      alloc_full   <= 1'b0;
      free_ack     <= '0;
      err_bad_free <= 1'b0;
      size_clr     <= 1'b0;
      size_clr_id  <= '0;
      in_use       <= '0;
    end else begin
      alloc_gnt    <= '0;
      alloc_full   <= 1'b0;
      free_ack     <= '0;
      err_bad_free <= 1'b0;
      case (state_r)
        INIT: begin
          size_clr    <= 1'b1;
          size_clr_id <= sweep_r;
          if (sweep_r == LastId) begin
            state_r <= RUN;
            ready   <= 1'b1;
            sweep_r <= '0;
          end else begin
            sweep_r <= sweep_r + W'(1);
          end
        end
        RUN: begin
          size_clr   <= doGrant_s;
          alloc_full <= doFull_s;
          if (doGrant_s) begin
            alloc_gnt   <= allocPick_s;
            alloc_id    <= grantId_s;
            size_clr_id <= grantId_s;
            inUseMap_r[grantId_s[IdxW-1:0]] <= 1'b1;
            allocPtr_r  <= allocPtrNext_s;
          end
          if (doFresh_s) begin
            fresh_r <= fresh_r + W'(1);
          end
          if (freeValid_s | freeBad_s) begin
            free_ack  <= freePick_s;
            freePtr_r <= freePtrNext_s;
          end
          err_bad_free <= freeBad_s;
          if (freeValid_s) begin
            inUseMap_r[freeSel_s[IdxW-1:0]] <= 1'b0;
          end
          // Push and pop together overwrite the top slot, leaving the depth unchanged.
          if (freeValid_s && doPop_s) begin
            stack_r[popIdx_s] <= freeSel_s;
          end else if (freeValid_s) begin
            stack_r[pushIdx_s] <= freeSel_s;
            stackTop_r         <= stackTop_r + W'(1);
          end else if (doPop_s) begin
            stackTop_r <= stackTop_r - W'(1);
          end
          case ({doGrant_s, freeValid_s})
            2'b10:   in_use <= in_use + W'(1);
            2'b01:   in_use <= in_use - W'(1);
            default: in_use <= in_use;
          endcase
        end
        default: begin
          state_r <= INIT;
          sweep_r <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_array_allocator.sv
// Directed self-checking bench for array_allocator (NArrays=16, NReq=2).
module tb_array_allocator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ready;
  logic [1:0]  alloc_req = 2'b00;
  logic [1:0]  alloc_gnt;
  logic [11:0] alloc_id;
  logic        alloc_full;
  logic [1:0]  free_req = 2'b00;
  logic [23:0] free_id = 24'd0;
  logic [1:0]  free_ack;
  logic        err_bad_free;
  logic        size_clr;
  logic [11:0] size_clr_id;
  logic [11:0] in_use;
  logic [11:0] high_water;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        ready;
    logic [1:0]  gnt;
    logic [11:0] id;
    logic        full;
    logic [1:0]  ack;
    logic        err;
    logic        clr;
    logic [11:0] clrId;
    logic [11:0] inUse;
    logic [11:0] hw;
  } obs_t;

  // One RUN-state step: stimulus, then expected outputs one edge later.
  typedef struct packed {
    logic [1:0]  areq;
    logic [1:0]  freq;
    logic [11:0] fid0;
    logic [11:0] fid1;
    logic [1:0]  gnt;
    logic [11:0] id;
    logic        full;
    logic [1:0]  ack;
    logic        err;
    logic [11:0] inUse;
    logic [11:0] hw;
  } step_t;

  array_allocator dut (
    .clock        (clock),
    .reset        (reset),
    .ready        (ready),
    .alloc_req    (alloc_req),
    .alloc_gnt    (alloc_gnt),
    .alloc_id     (alloc_id),
    .alloc_full   (alloc_full),
    .free_req     (free_req),
    .free_id      (free_id),
    .free_ack     (free_ack),
    .err_bad_free (err_bad_free),
    .size_clr     (size_clr),
    .size_clr_id  (size_clr_id),
    .in_use       (in_use),
    .high_water   (high_water)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Snapshot of the outputs; ids are zeroed where they carry no meaning.
  function automatic obs_t snap(input logic keepId, input logic keepClrId);
    obs_t o;
    o.ready = ready;
    o.gnt   = alloc_gnt;
    o.id    = keepId ? alloc_id : 12'd0;
    o.full  = alloc_full;
    o.ack   = free_ack;
    o.err   = err_bad_free;
    o.clr   = size_clr;
    o.clrId = keepClrId ? size_clr_id : 12'd0;
    o.inUse = in_use;
    o.hw    = high_water;
    return o;
  endfunction

  task automatic test_reset();
    obs_t got, expv;
    reset = 1'b1;
    tick();
    tick();
    got  = snap(1'b1, 1'b1);
    expv = '0;
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL reset_state got %h want %h", got, expv);
    end
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      got  = snap(1'b0, 1'b1);
      expv = '{(k == 15), 2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 1'b1, 12'(k), 12'd0, 12'd0};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL init_sweep cycle %0d got %h want %h", k, got, expv);
      end
    end
  endtask

  task automatic test_alloc_sequence();
    obs_t got, expv;
    step_t t [6] = '{
      '{2'b01, 2'b00, 12'd0, 12'd0, 2'b01, 12'd0, 1'b0, 2'b00, 1'b0, 12'd1, 12'd1},
      '{2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 12'd1, 12'd1},
      '{2'b01, 2'b00, 12'd0, 12'd0, 2'b01, 12'd1, 1'b0, 2'b00, 1'b0, 12'd2, 12'd2},
      '{2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 12'd2, 12'd2},
      '{2'b10, 2'b00, 12'd0, 12'd0, 2'b10, 12'd2, 1'b0, 2'b00, 1'b0, 12'd3, 12'd3},
      '{2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 12'd3, 12'd3}
    };
    for (int s = 0; s < 6; s++) begin
      alloc_req = t[s].areq; free_req = t[s].freq; free_id = {t[s].fid1, t[s].fid0};
      tick();
      got  = snap(t[s].gnt != 2'b00, t[s].gnt != 2'b00);
      expv = '{1'b1, t[s].gnt, t[s].id, t[s].full, t[s].ack, t[s].err,
               (t[s].gnt != 2'b00), t[s].id, t[s].inUse, t[s].hw};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL alloc_sequence step %0d got %h want %h", s, got, expv);
      end
    end
    alloc_req = 2'b00; free_req = 2'b00;
  endtask

  task automatic test_free_realloc();
    obs_t got, expv;
    step_t t [4] = '{
      '{2'b00, 2'b01, 12'd1, 12'd0, 2'b00, 12'd0, 1'b0, 2'b01, 1'b0, 12'd2, 12'd3},
      '{2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 12'd2, 12'd3},
      '{2'b01, 2'b00, 12'd0, 12'd0, 2'b01, 12'd1, 1'b0, 2'b00, 1'b0, 12'd3, 12'd3},
      '{2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 12'd3, 12'd3}
    };
    for (int s = 0; s < 4; s++) begin
      alloc_req = t[s].areq; free_req = t[s].freq; free_id = {t[s].fid1, t[s].fid0};
      tick();
      got  = snap(t[s].gnt != 2'b00, t[s].gnt != 2'b00);
      expv = '{1'b1, t[s].gnt, t[s].id, t[s].full, t[s].ack, t[s].err,
               (t[s].gnt != 2'b00), t[s].id, t[s].inUse, t[s].hw};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL free_realloc step %0d got %h want %h", s, got, expv);
      end
    end
    alloc_req = 2'b00; free_req = 2'b00;
  endtask

  task automatic test_simultaneous();
    obs_t got, expv;
    step_t t [10] = '{
      '{2'b10, 2'b00, 12'd0, 12'd0,  2'b10, 12'd3, 1'b0, 2'b00, 1'b0, 12'd4, 12'd4},
      '{2'b00, 2'b00, 12'd0, 12'd0,  2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 12'd4, 12'd4},
      '{2'b01, 2'b10, 12'd0, 12'd2,  2'b01, 12'd4, 1'b0, 2'b10, 1'b0, 12'd4, 12'd5},
      '{2'b00, 2'b00, 12'd0, 12'd0,  2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 12'd4, 12'd5},
      '{2'b00, 2'b01, 12'd2, 12'd0,  2'b00, 12'd0, 1'b0, 2'b01, 1'b1, 12'd4, 12'd5},
      '{2'b00, 2'b00, 12'd0, 12'd0,  2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 12'd4, 12'd5},
      '{2'b00, 2'b10, 12'd0, 12'd20, 2'b00, 12'd0, 1'b0, 2'b10, 1'b1, 12'd4, 12'd5},
      '{2'b00, 2'b00, 12'd0, 12'd0,  2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 12'd4, 12'd5},
      '{2'b01, 2'b00, 12'd0, 12'd0,  2'b01, 12'd2, 1'b0, 2'b00, 1'b0, 12'd5, 12'd5},
      '{2'b00, 2'b00, 12'd0, 12'd0,  2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 12'd5, 12'd5}
    };
    for (int s = 0; s < 10; s++) begin
      alloc_req = t[s].areq; free_req = t[s].freq; free_id = {t[s].fid1, t[s].fid0};
      tick();
      got  = snap(t[s].gnt != 2'b00, t[s].gnt != 2'b00);
      expv = '{1'b1, t[s].gnt, t[s].id, t[s].full, t[s].ack, t[s].err,
               (t[s].gnt != 2'b00), t[s].id, t[s].inUse, t[s].hw};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL simultaneous step %0d got %h want %h", s, got, expv);
      end
    end
    alloc_req = 2'b00; free_req = 2'b00;
  endtask

  task automatic test_reset_midrun();
    obs_t got, expv;
    step_t t [4] = '{
      '{2'b00, 2'b01, 12'd4, 12'd0, 2'b00, 12'd0, 1'b0, 2'b01, 1'b0, 12'd4, 12'd5},
      '{2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 12'd4, 12'd5},
      '{2'b00, 2'b10, 12'd0, 12'd3, 2'b00, 12'd0, 1'b0, 2'b10, 1'b0, 12'd3, 12'd5},
      '{2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 12'd3, 12'd5}
    };
    for (int s = 0; s < 4; s++) begin
      alloc_req = t[s].areq; free_req = t[s].freq; free_id = {t[s].fid1, t[s].fid0};
      tick();
      got  = snap(1'b0, 1'b0);
      expv = '{1'b1, t[s].gnt, 12'd0, t[s].full, t[s].ack, t[s].err,
               1'b0, 12'd0, t[s].inUse, t[s].hw};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL midrun_free step %0d got %h want %h", s, got, expv);
      end
    end
    free_req  = 2'b00;
    // Requester 0 keeps asking throughout reset and the sweep.
    alloc_req = 2'b01;
    reset     = 1'b1;
    tick();
    tick();
    got  = snap(1'b1, 1'b1);
    expv = '0;
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL midrun_reset_state got %h want %h", got, expv);
    end
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      got  = snap(1'b0, 1'b1);
      expv = '{(k == 15), 2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 1'b1, 12'(k), 12'd0, 12'd0};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL midrun_sweep cycle %0d got %h want %h", k, got, expv);
      end
    end
    tick();
    got  = snap(1'b1, 1'b1);
    expv = '{1'b1, 2'b01, 12'd0, 1'b0, 2'b00, 1'b0, 1'b1, 12'd0, 12'd1, 12'd1};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL midrun_first_alloc got %h want %h", got, expv);
    end
    alloc_req = 2'b00;
    tick();
    got  = snap(1'b0, 1'b0);
    expv = '{1'b1, 2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 1'b0, 12'd0, 12'd1, 12'd1};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL midrun_idle got %h want %h", got, expv);
    end
  endtask

  task automatic test_full();
    obs_t got, expv;
    step_t t [4] = '{
      '{2'b11, 2'b00, 12'd0, 12'd0, 2'b00, 12'd0, 1'b1, 2'b00, 1'b0, 12'd16, 12'd16},
      '{2'b11, 2'b01, 12'd5, 12'd0, 2'b00, 12'd0, 1'b1, 2'b01, 1'b0, 12'd15, 12'd16},
      '{2'b11, 2'b00, 12'd0, 12'd0, 2'b01, 12'd5, 1'b0, 2'b00, 1'b0, 12'd16, 12'd16},
      '{2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 12'd0, 1'b0, 2'b00, 1'b0, 12'd16, 12'd16}
    };
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (16) tick();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready got %b want 1", ready);
    end
    alloc_req = 2'b11;
    for (int k = 0; k < 16; k++) begin
      tick();
      got  = snap(1'b1, 1'b1);
      expv = '{1'b1, ((k % 2) == 0) ? 2'b01 : 2'b10, 12'(k), 1'b0, 2'b00, 1'b0,
               1'b1, 12'(k), 12'(k + 1), 12'(k + 1)};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL full_fill grant %0d got %h want %h", k, got, expv);
      end
    end
    for (int s = 0; s < 4; s++) begin
      alloc_req = t[s].areq; free_req = t[s].freq; free_id = {t[s].fid1, t[s].fid0};
      tick();
      got  = snap(t[s].gnt != 2'b00, t[s].gnt != 2'b00);
      expv = '{1'b1, t[s].gnt, t[s].id, t[s].full, t[s].ack, t[s].err,
               (t[s].gnt != 2'b00), t[s].id, t[s].inUse, t[s].hw};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL full_drain step %0d got %h want %h", s, got, expv);
      end
    end
    alloc_req = 2'b00; free_req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_alloc_sequence();
    test_free_realloc();
    test_simultaneous();
    test_reset_midrun();
    test_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
